trap_ctrl: RTL and testbench

- Parametrised trap and interrupt controller for the 5-stage RV32 pipeline; it is the next generation of the single-IRQ, fixed-vector exception path.
- Accepts NUM_IRQ level interrupt lines with a per-line mask and fixed priority, plus synchronous exceptions reported from EX (illegal opcode, misaligned access).
- Drives PC redirect and pipeline flush, holds MTVEC/MEPC/MCAUSE/MIE state, and handles MRET.
- Sits beside the EX stage; its redirect has priority over the branch redirect.

---
 rtl/trap_pkg.sv | 31 +++
 rtl/irq_prio_enc.sv | 25 ++
 rtl/trap_ctrl.sv | 169 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared encodings for the trap/interrupt controller: FSM states, CSR map,
// exception cause codes and the MIE global-enable bit position.
package trap_pkg;

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_TRAP    = 3'd1,
    S_HANDLER = 3'd2,
    S_RETURN  = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  localparam logic [1:0] CSR_MTVEC  = 2'd0;
  localparam logic [1:0] CSR_MEPC   = 2'd1;
  localparam logic [1:0] CSR_MCAUSE = 2'd2;
  localparam logic [1:0] CSR_MIE    = 2'd3;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;

  localparam int GIE_BIT = 31;

  // Vector slot for interrupt idx: base + 4*(idx+1); slot 0 is shared by exceptions.
  function automatic logic [31:0] irq_vector(input logic [31:0] base, input logic [3:0] idx);
    logic [31:0] off;
    off = {27'b0, ({1'b0, idx} + 5'd1)} << 2;
    return base + off;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over N request lines.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         vld,
  output logic [3:0]   idx,
  output logic [N-1:0] onehot
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    vld    = |req;
    idx    = '0;
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx       = 4'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap and interrupt controller beside EX: takes exceptions and masked,
// prioritised interrupts, redirects the PC, flushes the pipe and runs MRET.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int          NUM_IRQ  = 4,
  parameter logic [31:0] VEC_RST  = 32'h0000_0060,
  parameter bit          VECTORED = 1'b1,
  parameter bit          GIE_RST  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [NUM_IRQ-1:0] irq_ack,
  input  logic               ex_valid,
  input  logic [31:0]        ex_pc,
  input  logic               exc_valid,
  input  logic [3:0]         exc_cause,
  input  logic               mret_ex,
  input  logic               csr_we,
  input  logic [1:0]         csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               flush,
  output logic               in_handler,
  output logic               fault
);

  state_e             state_q, state_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [NUM_IRQ-1:0] mie_q, mie_d;
  logic               gie_q, gie_d;
  logic               pie_q, pie_d;
  logic               fault_q, fault_d;

  logic               pend_vld;
  logic [3:0]         pend_idx;
  logic [NUM_IRQ-1:0] pend_oh;
  logic [31:0]        mie_rd;

  irq_prio_enc #(.N(NUM_IRQ)) u_enc (
    .req    (irq & mie_q),
    .vld    (pend_vld),
    .idx    (pend_idx),
    .onehot (pend_oh)
  );

  // MIE read view: GIE on top, line masks at the bottom, zeros elsewhere.
  always_comb begin
    mie_rd                = '0;
    mie_rd[GIE_BIT]       = gie_q;
    mie_rd[NUM_IRQ-1:0]   = mie_q;
  end

  // Combinational CSR read port.
  always_comb begin
    case (csr_addr)
      CSR_MTVEC:  csr_rdata = mtvec_q;
      CSR_MEPC:   csr_rdata = mepc_q;
      CSR_MCAUSE: csr_rdata = mcause_q;
      default:    csr_rdata = mie_rd;
    endcase
  end

  // Next state and outputs; CSR writes are applied first so FSM updates override them.
  always_comb begin
    state_d     = state_q;
    mtvec_d     = mtvec_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mie_d       = mie_q;
    gie_d       = gie_q;
    pie_d       = pie_q;
    fault_d     = fault_q;
    irq_ack     = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    flush       = 1'b0;

    if (csr_we) begin
      case (csr_addr)
        CSR_MTVEC:  mtvec_d  = {csr_wdata[31:2], 2'b00};
        CSR_MEPC:   mepc_d   = csr_wdata;
        CSR_MCAUSE: mcause_d = csr_wdata;
        default: begin
          gie_d = csr_wdata[GIE_BIT];
          mie_d = csr_wdata[NUM_IRQ-1:0];
        end
      endcase
    end

    case (state_q)
      S_RUN: begin
        if (exc_valid) begin
          mepc_d   = ex_pc;
          mcause_d = {28'b0, exc_cause};
          flush    = 1'b1;
          state_d  = S_TRAP;
        end else if (gie_q && pend_vld && ex_valid) begin
          // EX instruction is squashed and replayed from MEPC after MRET.
          irq_ack  = pend_oh;
          mepc_d   = ex_pc;
          mcause_d = {1'b1, 27'b0, pend_idx};
          flush    = 1'b1;
          state_d  = S_TRAP;
        end
      end
      S_TRAP: begin
        redirect    = 1'b1;
        flush       = 1'b1;
        redirect_pc = (VECTORED && mcause_q[31]) ? irq_vector(mtvec_q, mcause_q[3:0]) : mtvec_q;
        pie_d       = gie_q;
        gie_d       = 1'b0;
        state_d     = S_HANDLER;
      end
      S_HANDLER: begin
        // A fault inside the handler is unrecoverable and beats MRET.
        if (exc_valid) begin
          flush   = 1'b1;
          fault_d = 1'b1;
          state_d = S_HALT;
        end else if (mret_ex) begin
          flush   = 1'b1;
          state_d = S_RETURN;
        end
      end
      S_RETURN: begin
        redirect    = 1'b1;
        redirect_pc = mepc_q;
        flush       = 1'b1;
        gie_d       = pie_q;
        state_d     = S_RUN;
      end
      S_HALT: flush = 1'b1;
      default: state_d = S_RUN;
    endcase
  end

  assign in_handler = (state_q == S_HANDLER);
  assign fault      = fault_q;

  // State and CSR registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RUN;
      mtvec_q  <= VEC_RST;
      mepc_q   <= '0;
      mcause_q <= '0;
      mie_q    <= '1;
      gie_q    <= GIE_RST;
      pie_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mie_q    <= mie_d;
      gie_q    <= gie_d;
      pie_q    <= pie_d;
      fault_q  <= fault_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: inputs change 1ns after the rising edge,
// outputs are checked 1ns later, well clear of the next edge.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic [3:0]  irq_ack;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic        mret_ex;
  logic        csr_we;
  logic [1:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        in_handler;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;

  trap_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .irq         (irq),
    .irq_ack     (irq_ack),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .exc_valid   (exc_valid),
    .exc_cause   (exc_cause),
    .mret_ex     (mret_ex),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush       (flush),
    .in_handler  (in_handler),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic clr();
    irq = '0; ex_valid = 0; ex_pc = '0; exc_valid = 0; exc_cause = '0;
    mret_ex = 0; csr_we = 0; csr_wdata = '0;
  endtask

  initial begin
    reset = 1'b0;
    csr_addr = 2'd0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_redirect", {31'b0, redirect}, 32'd0);
    chk("rst_flush",    {31'b0, flush}, 32'd0);
    chk("rst_ack",      {28'b0, irq_ack}, 32'd0);
    chk("rst_inh",      {31'b0, in_handler}, 32'd0);
    chk("rst_fault",    {31'b0, fault}, 32'd0);
    chk("rst_rpc",      redirect_pc, 32'd0);
    rd("rst_mtvec",  2'd0, 32'h0000_0060);
    rd("rst_mepc",   2'd1, 32'h0);
    rd("rst_mcause", 2'd2, 32'h0);
    rd("rst_mie",    2'd3, 32'h8000_000F);
    reset = 1'b1;
    tick();

    // interrupt: lowest pending line 1 wins
    irq = 4'b0110; ex_valid = 1; ex_pc = 32'h40;
    #1;
    chk("irq_ack",   {28'b0, irq_ack}, 32'h2);
    chk("irq_flush", {31'b0, flush}, 32'd1);
    chk("irq_nored", {31'b0, redirect}, 32'd0);
    tick();
    clr();
    #1;
    chk("trap_red",   {31'b0, redirect}, 32'd1);
    chk("trap_rpc",   redirect_pc, 32'h68);
    chk("trap_flush", {31'b0, flush}, 32'd1);
    rd("irq_mepc",   2'd1, 32'h40);
    rd("irq_mcause", 2'd2, 32'h8000_0001);
    tick();

    // handler ignores interrupts; GIE cleared
    chk("hnd_inh", {31'b0, in_handler}, 32'd1);
    rd("hnd_mie", 2'd3, 32'h0000_000F);
    irq = 4'hF; ex_valid = 1; ex_pc = 32'h80;
    #1;
    chk("hnd_noack", {28'b0, irq_ack}, 32'd0);
    chk("hnd_nored", {31'b0, redirect}, 32'd0);
    tick();
    clr();
    // MEPC rewrite in handler retargets the return
    csr_we = 1; csr_addr = 2'd1; csr_wdata = 32'h44;
    tick();
    clr();
    mret_ex = 1;
    #1;
    chk("mret_flush", {31'b0, flush}, 32'd1);
    tick();
    clr();
    #1;
    chk("ret_red", {31'b0, redirect}, 32'd1);
    chk("ret_rpc", redirect_pc, 32'h44);
    tick();
    chk("ret_inh", {31'b0, in_handler}, 32'd0);
    rd("ret_mie", 2'd3, 32'h8000_000F);

    // exception beats interrupt in same cycle
    exc_valid = 1; exc_cause = 4'd6; irq = 4'b0001; ex_valid = 1; ex_pc = 32'h24;
    #1;
    chk("exc_noack", {28'b0, irq_ack}, 32'd0);
    chk("exc_flush", {31'b0, flush}, 32'd1);
    tick();
    clr();
    #1;
    chk("exc_rpc", redirect_pc, 32'h60);
    rd("exc_mcause", 2'd2, 32'h6);
    rd("exc_mepc",   2'd1, 32'h24);
    tick();

    // fault inside handler -> HALT
    exc_valid = 1; exc_cause = 4'd2; mret_ex = 1;
    tick();
    clr();
    #1;
    chk("halt_fault", {31'b0, fault}, 32'd1);
    chk("halt_flush", {31'b0, flush}, 32'd1);
    chk("halt_nored", {31'b0, redirect}, 32'd0);
    tick();
    chk("halt_stay",  {31'b0, flush}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_fault_clr", {31'b0, fault}, 32'd0);
    chk("rst_flush_clr", {31'b0, flush}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // no interrupt without a real EX instruction
    irq = 4'b0001; ex_valid = 0;
    #1;
    chk("nov_ack",   {28'b0, irq_ack}, 32'd0);
    chk("nov_flush", {31'b0, flush}, 32'd0);
    clr();

    // masked line ignored
    csr_we = 1; csr_addr = 2'd3; csr_wdata = 32'h8000_0001;
    tick();
    clr();
    rd("mie_wr", 2'd3, 32'h8000_0001);
    irq = 4'b0100; ex_valid = 1; ex_pc = 32'h50;
    #1;
    chk("mask_ack",   {28'b0, irq_ack}, 32'd0);
    chk("mask_flush", {31'b0, flush}, 32'd0);
    tick();
    clr();
    #1;
    chk("mask_nored", {31'b0, redirect}, 32'd0);
    csr_we = 1; csr_addr = 2'd0; csr_wdata = 32'h203;
    tick();
    clr();
    rd("mtvec_wr", 2'd0, 32'h200);

    // trap entry overrides a simultaneous MCAUSE write
    irq = 4'b0001; ex_valid = 1; ex_pc = 32'h80;
    csr_we = 1; csr_addr = 2'd2; csr_wdata = 32'h55;
    #1;
    chk("ovr_ack", {28'b0, irq_ack}, 32'h1);
    tick();
    clr();
    #1;
    chk("ovr_rpc", redirect_pc, 32'h204);
    rd("ovr_mcause", 2'd2, 32'h8000_0000);
    rd("ovr_mepc",   2'd1, 32'h80);

    // reset mid-TRAP
    reset = 1'b0;
    #1;
    chk("mrst_red", {31'b0, redirect}, 32'd0);
    rd("mrst_mtvec",  2'd0, 32'h60);
    rd("mrst_mepc",   2'd1, 32'h0);
    rd("mrst_mcause", 2'd2, 32'h0);
    rd("mrst_mie",    2'd3, 32'h8000_000F);
    tick();
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
